sipo_shift_reg: RTL and testbench

//  Serial-in/parallel-out capture register. Consumes the 1-bit Q stream of the

---
 rtl/sipo_shift_reg.sv | 165 ++++++++++++++++
 tb/tb_sipo_shift_reg.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_shift_reg.sv
// -----------------------------------------------------------------------------
// sipo_shift_reg
//   Serial-in / parallel-out capture register. Collects a 1-bit stream LSB
//   first, one bit per CLK edge with Shift=1, and presents the completed
//   WIDTH-bit word on Q with a Valid/Ready handshake. A completed word is held
//   until accepted; extra Shift pulses while full are dropped and flagged on
//   the sticky Overrun output.
//
//   Optional feature macro: SIPO_PARITY_EN
//     When defined, each frame carries one trailing even-parity bit. The
//     parity bit is kept out of Q. Parity_err reports a parity error
//     alongside Valid. When undefined, the Parity_err port does not exist.
// -----------------------------------------------------------------------------
module sipo_shift_reg #(
   parameter  int WIDTH = 8,
   localparam int CW    = $clog2(WIDTH + 2)
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             D,
   input  logic             Shift,
   input  logic             Ready,
   output logic [WIDTH-1:0] Q,
   output logic             Valid,
   output logic [CW-1:0]    Count,
   output logic             Overrun
`ifdef SIPO_PARITY_EN
  ,output logic             Parity_err
`endif
);

`ifdef SIPO_PARITY_EN
   localparam int FL = WIDTH + 1;
`else
   localparam int FL = WIDTH;
`endif
   // Count value held while the edge samples the final bit of a frame.
   localparam logic [CW-1:0] LAST_CNT = CW'(FL - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_FULL
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sreg_q,  sreg_d;
   logic [WIDTH-1:0] q_q,     q_d;
   logic [CW-1:0]    cnt_q,   cnt_d;
   logic             valid_q, valid_d;
   logic             ovr_q,   ovr_d;
`ifdef SIPO_PARITY_EN
   logic             perr_q,  perr_d;
`endif

   // Shift register contents after taking D in at the top (LSB-first stream).
   logic [WIDTH-1:0] shifted;
   assign shifted = {D, sreg_q[WIDTH-1:1]};

   // Next-state logic for the frame state machine and its registered outputs.
   always_comb begin
      // NOTE: every next value defaults to its current value first, so no path
      // leaves one unassigned and no latch is inferred.
      state_d = state_q;
      sreg_d  = sreg_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
`ifdef SIPO_PARITY_EN
      perr_d  = perr_q;
`endif

      case (state_q)
         S_IDLE, S_SHIFT: begin
            if (Shift) begin
               cnt_d = cnt_q + 1'b1;
`ifdef SIPO_PARITY_EN
               if (cnt_q == LAST_CNT) begin
                  // Parity bit: checked against the data, never shifted in.
                  q_d     = sreg_q;
                  perr_d  = ^{sreg_q, D};
                  valid_d = 1'b1;
                  state_d = S_FULL;
               end else begin
                  sreg_d  = shifted;
                  state_d = S_SHIFT;
               end
`else
               sreg_d = shifted;
               if (cnt_q == LAST_CNT) begin
                  q_d     = shifted;
                  valid_d = 1'b1;
                  state_d = S_FULL;
               end else begin
                  state_d = S_SHIFT;
               end
`endif
            end
         end

         S_FULL: begin
            if (Ready) begin
               valid_d = 1'b0;
               ovr_d   = 1'b0;
`ifdef SIPO_PARITY_EN
               perr_d  = 1'b0;
`endif
               if (Shift) begin
                  // Accept and first bit of the next frame on the same edge.
                  sreg_d  = shifted;
                  cnt_d   = CW'(1);
                  state_d = S_SHIFT;
               end else begin
                  cnt_d   = '0;
                  state_d = S_IDLE;
               end
            end else if (Shift) begin
               // Word still unaccepted: the incoming bit is lost.
               ovr_d = 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset discards any partial frame at once.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= S_IDLE;
         sreg_q  <= '0;
         q_q     <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
`ifdef SIPO_PARITY_EN
         perr_q  <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         state_q <= state_d;
         sreg_q  <= sreg_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
`ifdef SIPO_PARITY_EN
         perr_q  <= perr_d;
`endif
      end
   end

   assign Q       = q_q;
   assign Valid   = valid_q;
   assign Count   = cnt_q;
   assign Overrun = ovr_q;
`ifdef SIPO_PARITY_EN
   assign Parity_err = perr_q;
`endif

endmodule

// File: tb/tb_sipo_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_sipo_shift_reg
//   Self-checking bench for sipo_shift_reg (WIDTH=8). A frame-level model
//   (a queue of received bits plus the held word) predicts every output; a
//   compare process checks the DUT against it on each falling edge. Directed
//   sequences with literal expectations come first, then randomized traffic
//   with occasional asynchronous resets.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sipo_shift_reg;

   localparam int W  = 8;
   localparam int CW = $clog2(W + 2);
`ifdef SIPO_PARITY_EN
   localparam int FL = W + 1;
`else
   localparam int FL = W;
`endif

   logic          CLK;
   logic          RST_N;
   logic          D;
   logic          Shift;
   logic          Ready;
   logic [W-1:0]  Q;
   logic          Valid;
   logic [CW-1:0] Count;
   logic          Overrun;
`ifdef SIPO_PARITY_EN
   logic          Parity_err;
`endif

   sipo_shift_reg #(.WIDTH(W)) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .D          (D),
      .Shift      (Shift),
      .Ready      (Ready),
      .Q          (Q),
      .Valid      (Valid),
      .Count      (Count),
      .Overrun    (Overrun)
`ifdef SIPO_PARITY_EN
     ,.Parity_err (Parity_err)
`endif
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_en   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- frame-level reference model ----------------
   bit           m_bits[$];      // bits of the frame in progress, first bit at [0]
   logic [W-1:0] m_q     = '0;   // last completed word
   bit           m_valid = 1'b0;
   bit           m_ovr   = 1'b0;
   bit           m_perr  = 1'b0;

   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         m_bits.delete();
         m_q     = '0;
         m_valid = 1'b0;
         m_ovr   = 1'b0;
         m_perr  = 1'b0;
      end else if (m_valid) begin
         if (Ready) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            m_perr  = 1'b0;
            m_bits.delete();
            if (Shift) m_bits.push_back(D);
         end else if (Shift) begin
            m_ovr = 1'b1;
         end
      end else if (Shift) begin
         m_bits.push_back(D);
         if (m_bits.size() == FL) begin
            bit par;
            par = 1'b0;
            for (int i = 0; i < FL; i++) par = par ^ m_bits[i];
            for (int i = 0; i < W; i++) m_q[i] = m_bits[i];
            m_perr  = par;
            m_valid = 1'b1;
            m_bits.delete();
         end
      end
   end

   function automatic int m_count();
      return m_valid ? FL : m_bits.size();
   endfunction

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge CLK) begin
      if (cmp_en && RST_N) begin
         check("Q",       32'(Q),       32'(m_q));
         check("Valid",   32'(Valid),   32'(m_valid));
         check("Count",   32'(Count),   32'(m_count()));
         check("Overrun", 32'(Overrun), 32'(m_ovr));
`ifdef SIPO_PARITY_EN
         check("Parity_err", 32'(Parity_err), 32'(m_perr));
`endif
      end
   end

   // ---------------- stimulus helpers ----------------
   // Apply inputs, let the next rising edge sample them, return 1ns after it.
   task automatic drive(input bit s, input bit d, input bit r);
      Shift = s;
      D     = d;
      Ready = r;
      @(posedge CLK);
      #1;
   endtask

   task automatic send_word(input logic [W-1:0] w);
      for (int i = 0; i < W; i++) drive(1'b1, w[i], 1'b0);
   endtask

   initial begin
      RST_N = 1'b0;
      D     = 1'b0;
      Shift = 1'b0;
      Ready = 1'b0;
      #2;
      check("reset_Q",     32'(Q),       32'h0);
      check("reset_Valid", 32'(Valid),   32'h0);
      check("reset_Count", 32'(Count),   32'h0);
      check("reset_Ovr",   32'(Overrun), 32'h0);
      #10 RST_N = 1'b1;
      @(posedge CLK);
      #1;
      cmp_en = 1'b1;

`ifndef SIPO_PARITY_EN
      // 1: LSB-first 1,0,1,0,0,1,0,1 -> 8'hA5 on the 8th edge.
      send_word(8'hA5);
      check("t1_Q",     32'(Q),       32'hA5);
      check("t1_Valid", 32'(Valid),   32'h1);
      check("t1_Count", 32'(Count),   32'd8);
      check("t1_Ovr",   32'(Overrun), 32'h0);

      // 2: three more bits while unaccepted are dropped, Overrun sticks.
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0);
      check("t2_Q",     32'(Q),       32'hA5);
      check("t2_Valid", 32'(Valid),   32'h1);
      check("t2_Count", 32'(Count),   32'd8);
      check("t2_Ovr",   32'(Overrun), 32'h1);

      // 3: accept and first bit of the next frame on the same edge.
      drive(1'b1, 1'b1, 1'b1);
      check("t3_Valid", 32'(Valid),   32'h0);
      check("t3_Ovr",   32'(Overrun), 32'h0);
      check("t3_Count", 32'(Count),   32'd1);
      check("t3_Q",     32'(Q),       32'hA5);

      // 4: partial frame then async reset between edges.
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
      check("t4_pre_Count", 32'(Count), 32'd3);
      Shift = 1'b0;
      #1 RST_N = 1'b0;
      #1;
      check("t4_rst_Q",     32'(Q),     32'h0);
      check("t4_rst_Valid", 32'(Valid), 32'h0);
      check("t4_rst_Count", 32'(Count), 32'h0);
      #1 RST_N = 1'b1;
      @(posedge CLK);
      #1;
      send_word(8'h3C);
      check("t4_Q",     32'(Q),     32'h3C);
      check("t4_Valid", 32'(Valid), 32'h1);
      drive(1'b0, 1'b0, 1'b1);
      check("t4_acc_Valid", 32'(Valid), 32'h0);
      check("t4_acc_Q",     32'(Q),     32'h3C);
      check("t4_acc_Count", 32'(Count), 32'h0);

      // 5: one bit every fourth cycle; Count moves only on Shift edges.
      for (int i = 0; i < W; i++) begin
         logic [W-1:0] w;
         w = 8'h81;
         drive(1'b1, w[i], 1'b0);
         check("t5_Count", 32'(Count), (i == W - 1) ? 32'd8 : 32'(i + 1));
         for (int g = 0; g < 3; g++) drive(1'b0, 1'b1, 1'b1 & (i != W - 1));
         check("t5_hold_Count", 32'(Count), (i == W - 1) ? 32'd8 : 32'(i + 1));
      end
      check("t5_Q",     32'(Q),     32'h81);
      check("t5_Valid", 32'(Valid), 32'h1);
      drive(1'b0, 1'b0, 1'b1);
`else
      // 6: 8'hA5 with parity bit 1 -> error; with parity bit 0 -> clean.
      send_word(8'hA5);
      check("t6_Valid_pre", 32'(Valid), 32'h0);
      check("t6_Count_pre", 32'(Count), 32'd8);
      drive(1'b1, 1'b1, 1'b0);
      check("t6_Q",     32'(Q),          32'hA5);
      check("t6_Valid", 32'(Valid),      32'h1);
      check("t6_Count", 32'(Count),      32'd9);
      check("t6_perr",  32'(Parity_err), 32'h1);
      drive(1'b0, 1'b0, 1'b1);
      check("t6_acc_perr", 32'(Parity_err), 32'h0);
      send_word(8'hA5);
      drive(1'b1, 1'b0, 1'b0);
      check("t6b_Q",    32'(Q),          32'hA5);
      check("t6b_perr", 32'(Parity_err), 32'h0);
      drive(1'b0, 1'b0, 1'b1);
`endif

      // Randomized traffic with occasional mid-cycle resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            RST_N = 1'b0;
            #1;
            check("rnd_rst_Valid", 32'(Valid), 32'h0);
            check("rnd_rst_Count", 32'(Count), 32'h0);
            #1 RST_N = 1'b1;
         end
         drive($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 3);
      end

      @(negedge CLK);
      #1;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
